// File: rtl/div_tick_timer.sv
// Tap-select edge-to-tick converter driving a down-counting one-shot timer, all on clk.
// Optional periodic reload when DIV_TICK_AUTO_RELOAD_EN is defined.
module div_tick_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div2,
  input  logic             div4,
  input  logic             div8,
  input  logic             div16,
  input  logic [1:0]       sel,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sel_q, w_sel_nxt;
  logic             r_prev;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_done, w_done_nxt;
  logic             w_sig;
  logic             w_edge;
  logic [WIDTH-1:0] w_reload_src;

`ifdef DIV_TICK_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload_q;
  assign w_reload_src = r_reload_q;
`else
  assign w_reload_src = '0;
`endif

  always_comb begin
    w_sig = div2;
    case (r_sel_q)
      2'd0: w_sig = div2;
      2'd1: w_sig = div4;
      2'd2: w_sig = div8;
      2'd3: w_sig = div16;
      default: w_sig = div2;
    endcase
  end

  // prev tracks the registered tap every cycle, so ARM seeds it with the new tap.
  assign w_edge = w_sig & ~r_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel_q;
    w_count_nxt = r_count;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          if (load_val != '0) begin
            w_sel_nxt   = sel;
            w_count_nxt = load_val;
            w_state_nxt = S_ARM;
          end else begin
            w_count_nxt = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_ARM: begin
        w_state_nxt = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_edge && (r_count != '0)) begin
          w_tick_nxt = 1'b1;
          if (r_count == WIDTH'(1)) begin
            w_done_nxt = 1'b1;
`ifdef DIV_TICK_AUTO_RELOAD_EN
            w_count_nxt = w_reload_src;
`else
            w_count_nxt = w_reload_src;
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel_q <= 2'd0;
      r_prev  <= 1'b0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel_q <= w_sel_nxt;
      r_prev  <= w_sig;
      r_count <= w_count_nxt;
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef DIV_TICK_AUTO_RELOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reload_q <= '0;
    end else if ((r_state == S_IDLE) && start && !stop) begin
      r_reload_q <= load_val;
    end
  end
`endif

  assign tick  = r_tick;
  assign done  = r_done;
  assign busy  = (r_state == S_ARM) || (r_state == S_RUN);
  assign count = r_count;

endmodule

// File: tb/tb_div_tick_timer.sv
// Bench for div_tick_timer: table-driven runs, hand corner sequences and random stimulus,
// all checked cycle by cycle against an arithmetic reference of the divider taps.
module tb_div_tick_timer;
  localparam int W = 8;
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst;
  logic div2, div4, div8, div16;
  logic [1:0] sel;
  logic start, stop;
  logic [W-1:0] load_val;
  logic tick, busy, done;
  logic [W-1:0] count;

  div_tick_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .div2(div2), .div4(div4), .div8(div8), .div16(div16),
    .sel(sel), .start(start), .stop(stop), .load_val(load_val),
    .tick(tick), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  int unsigned cyc;
  int n_tests = 0;
  int n_fail = 0;

  int m_mode;
  int m_sel;
  int m_count;
  int m_reload;
  bit m_tick, m_busy, m_done;

  int n_ticks, last_tick, gap_min, gap_max;
  bit done_seen;

  typedef struct {
    logic [1:0] sel;
    logic [W-1:0] load;
    int exp_ticks;
    int exp_gap;
  } vec_t;
  vec_t vecs[5];

  function automatic bit tap(input int s, input int unsigned c);
    return ((c >> s) & 1) != 0;
  endfunction

  task automatic drive_div();
    div2  = tap(0, cyc);
    div4  = tap(1, cyc);
    div8  = tap(2, cyc);
    div16 = tap(3, cyc);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_sel = 0; m_count = 0; m_reload = 0;
    m_tick = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_update();
    bit e;
    m_tick = 0;
    m_done = 0;
    if (rst) begin
      model_reset();
      return;
    end
    e = (cyc > 0) && tap(m_sel, cyc) && !tap(m_sel, cyc - 1);
    case (m_mode)
      M_IDLE: if (start && !stop) begin
        if (load_val != 0) begin
          m_sel = sel; m_count = load_val; m_reload = load_val; m_mode = M_ARM;
        end else begin
          m_count = 0; m_done = 1; m_mode = M_DONE;
        end
      end
      M_ARM: m_mode = stop ? M_IDLE : M_RUN;
      M_RUN: begin
        if (stop) m_mode = M_IDLE;
        else if (e && m_count >= 1) begin
          m_tick = 1;
          m_count = m_count - 1;
          if (m_count == 0) begin
            m_done = 1;
`ifdef DIV_TICK_AUTO_RELOAD_EN
            m_count = m_reload;
`else
            m_mode = M_DONE;
`endif
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    m_busy = (m_mode == M_ARM) || (m_mode == M_RUN);
  endtask

  task automatic clear_stats();
    n_ticks = 0; last_tick = 0; gap_min = 1 << 20; gap_max = 0; done_seen = 0;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    drive_div();
    check("outs", {5'd0, tick, busy, done, count},
          {5'd0, m_tick, m_busy, m_done, W'(m_count)});
    if (tick) begin
      if (n_ticks > 0) begin
        if (int'(cyc) - last_tick < gap_min) gap_min = int'(cyc) - last_tick;
        if (int'(cyc) - last_tick > gap_max) gap_max = int'(cyc) - last_tick;
      end
      last_tick = int'(cyc);
      n_ticks++;
    end
    if (done) done_seen = 1;
  endtask

  initial begin
    int budget;
    cyc = 0;
    drive_div();
    rst = 1; sel = 0; start = 0; stop = 0; load_val = 0;
    model_reset();
    clear_stats();
    repeat (3) step();
    rst = 0;
    step();
    check("reset_idle", {tick, busy, done, count}, '0);

`ifndef DIV_TICK_AUTO_RELOAD_EN
    vecs[0] = '{2'd0, 8'd3, 3, 2};
    vecs[1] = '{2'd1, 8'd5, 5, 4};
    vecs[2] = '{2'd2, 8'd2, 2, 8};
    vecs[3] = '{2'd3, 8'd2, 2, 16};
    vecs[4] = '{2'd0, 8'd1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      sel = vecs[i].sel; load_val = vecs[i].load; start = 1;
      step();
      start = 0;
      clear_stats();
      budget = 0;
      while (!done_seen && budget < 300) begin step(); budget++; end
      check("done_seen", 16'(done_seen), 16'd1);
      check("tick_count", 16'(n_ticks), 16'(vecs[i].exp_ticks));
      if (vecs[i].exp_ticks > 1) begin
        check("gap_min", 16'(gap_min), 16'(vecs[i].exp_gap));
        check("gap_max", 16'(gap_max), 16'(vecs[i].exp_gap));
      end
      step();
      check("idle_after_done", {busy, done}, 2'b00);
    end

    // seeding: start on the cycle div16 has just risen
    while ((cyc % 16) != 8) step();
    sel = 3; load_val = 2; start = 1;
    step();
    start = 0;
    clear_stats();
    repeat (6) step();
    check("seed_no_tick", 16'(n_ticks), 16'd0);
    budget = 0;
    while (!done_seen && budget < 100) begin step(); budget++; end
    check("seed_ticks", 16'(n_ticks), 16'd2);
    check("seed_gap", 16'(gap_max), 16'd16);
    step();

    // stop coinciding with an edge at count 4
    sel = 0; load_val = 6; start = 1;
    step();
    start = 0;
    budget = 0;
    while (!(m_mode == M_RUN && m_count == 4 && tap(0, cyc) && !tap(0, cyc - 1)) && budget < 50) begin
      step(); budget++;
    end
    check("stop_reached", 16'(m_count), 16'd4);
    stop = 1;
    step();
    stop = 0;
    check("stop_prio", {tick, busy, done, count}, {3'b000, 8'd4});
    step();

    // start together with stop in IDLE
    start = 1; stop = 1; load_val = 5;
    step();
    start = 0; stop = 0;
    check("start_stop_idle", {busy, done}, 2'b00);
    step();

    // zero load
    load_val = 0; start = 1;
    step();
    start = 0;
    check("zero_load", {tick, busy, done}, 3'b001);
    step();
    check("zero_load_after", {tick, busy, done}, 3'b000);

    // start with new sel while running is ignored
    sel = 0; load_val = 4; start = 1;
    step();
    start = 0;
    clear_stats();
    repeat (3) step();
    sel = 2; load_val = 9; start = 1;
    step();
    start = 0;
    budget = 0;
    while (!done_seen && budget < 100) begin step(); budget++; end
    check("ign_ticks", 16'(n_ticks), 16'd4);
    check("ign_gap", 16'(gap_max), 16'd2);
    step();
`else
    sel = 1; load_val = 2; start = 1;
    step();
    start = 0;
    clear_stats();
    budget = 0;
    begin
      int last_done, n_done, dgap;
      last_done = 0; n_done = 0; dgap = 0;
      while (budget < 60) begin
        step(); budget++;
        if (done) begin
          if (n_done > 0) dgap = int'(cyc) - last_done;
          last_done = int'(cyc); n_done++;
        end
      end
      check("ar_done_gap", 16'(dgap), 16'd8);
      check("ar_busy", 16'(busy), 16'd1);
    end
    stop = 1;
    step();
    stop = 0;
    check("ar_stop", 16'(busy), 16'd0);
    step();
`endif

    // asynchronous reset in the middle of a run
    sel = 0; load_val = 8; start = 1;
    step();
    start = 0;
    budget = 0;
    while (m_count != 5 && budget < 50) begin step(); budget++; end
    #2;
    rst = 1;
    model_reset();
    #1;
    check("async_reset", {tick, busy, done, count}, '0);
    step();
    rst = 0;
    clear_stats();
    repeat (10) step();
    check("no_tick_after_reset", 16'(n_ticks), 16'd0);

    // random stimulus against the reference
    for (int k = 0; k < 600; k++) begin
      sel = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 23) == 0);
      load_val = W'($urandom_range(0, 5));
      step();
    end
    start = 0; stop = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
